mem_burst_master: RTL and testbench

- Initiator that drives the team's synchronous dual-port RAM (1-cycle registered read, write on clock edge) on behalf of a CPU-side client.
- Accepts single-word or burst read/write requests over a valid/ready handshake.
- Streams write data into the RAM write port and read data out of the RAM read port at full throughput (one word per cycle), with backpressure on the read stream.
- Sits between the CPU datapath / DMA-style client and one RAM instance.

---
 rtl/mem_burst_master.sv | 113 +++++++++++
 tb/tb_mem_burst_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst initiator for a dual-port RAM with a registered 1-cycle read and a write on the clock edge.
// Accepts single or burst requests and streams one word per cycle in either direction.
module mem_burst_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_write_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  rd_fire;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign rd_fire  = (state_q == StRd) && rd_ready_i;
  assign wr_fire  = (state_q == StWr) && wr_valid_i;
  assign addr_inc = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d      = req_addr_i;
          remaining_d = req_len_i;
          busy_d      = 1'b1;
          state_d     = req_write_i ? StWr : StRd;
        end
      end
      StRd, StWr: begin
        if (rd_fire || wr_fire) begin
          addr_d = addr_inc;
          if (remaining_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Read address runs one beat ahead on a fire so the registered RAM output tracks the current beat.
  always_comb begin
    mem_addr_read_o = addr_q;
    if (state_q == StIdle) begin
      mem_addr_read_o = req_addr_i;
    end else if (rd_fire) begin
      mem_addr_read_o = addr_inc;
    end
  end

  assign req_ready_o      = (state_q == StIdle);
  assign wr_ready_o       = (state_q == StWr);
  assign rd_valid_o       = (state_q == StRd);
  assign rd_data_o        = mem_data_out_i;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mem_we_o         = wr_fire;
  assign mem_addr_write_o = addr_q;
  assign mem_wdata_o      = wr_data_i;

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: RAM model, transaction-level reference model, per-cycle compare
// process, directed scenarios with literal expectations and a randomized burst phase.
module tb_mem_burst_master;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid, req_write, wr_valid, rd_ready;
  logic [7:0] req_addr, wr_data;
  logic [3:0] req_len;
  logic       req_ready, wr_ready, rd_valid, busy, done, mem_we;
  logic [7:0] rd_data, mem_addr_write, mem_wdata, mem_addr_read;
  logic [7:0] mem_data_out;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  // Transaction-level model: active burst, base address, beat count and beats done.
  logic       m_active = 1'b0;
  logic       m_write  = 1'b0;
  logic       m_done   = 1'b0;
  logic [7:0] m_base   = 8'h00;
  int         m_cnt    = 0;
  int         m_k      = 0;

  byte_q_t    rd_log;
  byte_q_t    we_log;
  int         done_cnt;
  logic [7:0] ea;

  mem_burst_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .LEN_WIDTH (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_addr_i      (req_addr),
    .req_len_i       (req_len),
    .wr_data_i       (wr_data),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .busy_o          (busy),
    .done_o          (done),
    .mem_we_o        (mem_we),
    .mem_addr_write_o(mem_addr_write),
    .mem_wdata_o     (mem_wdata),
    .mem_addr_read_o (mem_addr_read),
    .mem_data_out_i  (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr_write] <= mem_wdata;
    mem_data_out <= ram[mem_addr_read];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input byte_q_t got, input byte_q_t exp);
    chk({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(name, (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp[i]});
    end
  endtask

  // Reference model: a burst of len+1 beats, beat k at base+k (mod 256), done after the last beat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_k      <= 0;
      m_cnt    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_write ? wr_valid : rd_ready) begin
          if (m_write) ref_mem[m_base + m_k[7:0]] <= wr_data;
          m_k <= m_k + 1;
          if (m_k + 1 == m_cnt) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
          end
        end
      end else if (req_valid) begin
        m_active <= 1'b1;
        m_write  <= req_write;
        m_base   <= req_addr;
        m_cnt    <= int'(req_len) + 1;
        m_k      <= 0;
      end
    end
  end

  always @(negedge clk) begin
    ea = m_base + m_k[7:0];
    chk("req_ready", req_ready, !m_active);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("wr_ready", wr_ready, m_active && m_write);
    chk("rd_valid", rd_valid, m_active && !m_write);
    chk("mem_we", mem_we, m_active && m_write && wr_valid);
    if (m_active && m_write && wr_valid) begin
      chk("mem_addr_write", mem_addr_write, ea);
      chk("mem_wdata", mem_wdata, wr_data);
    end
    if (m_active && !m_write) chk("rd_data", rd_data, ref_mem[ea]);
    if (!m_active) chk("mem_addr_read idle", mem_addr_read, req_addr);
    if (!rst && rd_valid && rd_ready) rd_log.push_back(rd_data);
    if (mem_we) we_log.push_back(mem_addr_write);
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    rd_log.delete();
    we_log.delete();
    done_cnt = 0;
  endtask

  task automatic garbage_req();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = 8'($urandom);
    req_len   = 4'($urandom);
  endtask

  task automatic do_req(input logic w, input logic [7:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_len   = 4'($urandom);
  endtask

  task automatic write_beats(input byte_q_t d, input int mode);
    int i = 0;
    int c = 0;
    while (i < d.size() && c < 300) begin
      wr_valid = (mode == 0) ? 1'b1 : 1'($urandom);
      wr_data  = d[i];
      garbage_req();
      @(posedge clk);
      #1;
      if (wr_valid) i++;
      c++;
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    if (i < d.size()) chk("write beats timeout", i, d.size());
  endtask

  task automatic read_beats(input int n, input int mode);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int i = 0;
    int c = 0;
    while (i < n && c < 300) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[c % 7] : 1'($urandom);
      garbage_req();
      @(posedge clk);
      #1;
      if (rd_ready) i++;
      c++;
    end
    rd_ready  = 1'b0;
    req_valid = 1'b0;
    if (i < n) chk("read beats timeout", i, n);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t d;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    done_cnt  = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h10;
    req_len   = 4'd3;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;

    // Held request during reset is taken on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    clear_logs();
    @(posedge clk);
    #1;
    chk("first accept busy", busy, 1);
    chk("first accept wr_ready", wr_ready, 1);
    req_valid = 1'b0;
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    write_beats(d, 0);
    chk("write done pulse", done, 1);
    idle_cycle();
    chk("write busy after", busy, 0);
    chk("write done count", done_cnt, 1);
    chk_q("write addrs", we_log, '{8'h10, 8'h11, 8'h12, 8'h13});

    clear_logs();
    do_req(1'b0, 8'h10, 4'd3);
    chk("read rd_valid after accept", rd_valid, 1);
    read_beats(4, 0);
    idle_cycle();
    chk_q("read data", rd_log, '{8'hA1, 8'hA2, 8'hA3, 8'hA4});
    chk("read done count", done_cnt, 1);

    clear_logs();
    do_req(1'b0, 8'h10, 4'd3);
    read_beats(4, 1);
    idle_cycle();
    chk_q("stall read data", rd_log, '{8'hA1, 8'hA2, 8'hA3, 8'hA4});
    chk("stall done count", done_cnt, 1);

    // Address wrap through 0xFF -> 0x00, read issued in the done cycle of the write.
    clear_logs();
    do_req(1'b1, 8'hFE, 4'd2);
    d = '{8'h11, 8'h22, 8'h33};
    write_beats(d, 0);
    do_req(1'b0, 8'hFE, 4'd2);
    read_beats(3, 0);
    idle_cycle();
    chk_q("wrap write addrs", we_log, '{8'hFE, 8'hFF, 8'h00});
    chk_q("wrap read data", rd_log, '{8'h11, 8'h22, 8'h33});

    // Reset during beat 2 of an 8-beat write abandons the burst.
    clear_logs();
    do_req(1'b1, 8'h40, 4'd7);
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    @(posedge clk);
    #1;
    wr_data = 8'h6B;
    #3;
    rst = 1'b1;
    #1;
    chk("abort mem_we", mem_we, 0);
    chk("abort req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_valid = 1'b0;
    idle_cycle();
    chk("abort busy", busy, 0);
    chk("abort done count", done_cnt, 0);
    do_req(1'b0, 8'h40, 4'd0);
    read_beats(1, 0);
    do_req(1'b0, 8'h41, 4'd0);
    read_beats(1, 0);
    idle_cycle();
    chk_q("abort readback", rd_log, '{8'h5A, 8'h00});

    // Randomized bursts, full-length bursts included, checked by the model every cycle.
    for (int n = 0; n < 60; n++) begin
      logic       w;
      logic [7:0] a;
      logic [3:0] l;
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'hF8 + 8'($urandom_range(0, 7)) : 8'($urandom);
      l = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
      do_req(w, a, l);
      if (w) begin
        d.delete();
        for (int i = 0; i <= int'(l); i++) d.push_back(8'($urandom));
        write_beats(d, int'($urandom_range(0, 1)) * 2);
      end else begin
        read_beats(int'(l) + 1, int'($urandom_range(0, 2)));
      end
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
